instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 133 +++++++++++++
 tb/tb_instruction_fetch.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, registered fetch, branch flush, optional NOP delay.
// Define INSTRUCTION_FETCH_NOP_DELAY_EN to make NOP immediates stall issue N cycles.
module instruction_fetch #(
  parameter int         ADDR_W     = 16,
  parameter int         INSN_W     = 28,
  parameter logic [3:0] NOP_OPCODE = 4'd0
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic [ADDR_W-1:0] oAddress,
  input  logic [INSN_W-1:0] iInstruction,
  input  logic              iStall,
  input  logic              iBranchTaken,
  input  logic [ADDR_W-1:0] iBranchTarget,
  output logic [INSN_W-1:0] oInstruction,
  output logic [ADDR_W-1:0] oPC,
  output logic              oValid
);

`ifdef INSTRUCTION_FETCH_NOP_DELAY_EN
  localparam int CNT_W = 24;
  typedef enum logic [1:0] {FETCH, FLUSH, DELAY} state_t;
`else
  typedef enum logic {FETCH, FLUSH} state_t;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] opc_q, opc_d;
  logic [INSN_W-1:0] insn_q, insn_d;
  logic              valid_q, valid_d;
  logic [3:0]        opcode;
  logic              do_branch;
  logic              do_hold;
  logic              do_count;
  logic              do_fetch;

  assign opcode = iInstruction[INSN_W-1 -: 4];

`ifdef INSTRUCTION_FETCH_NOP_DELAY_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] imm_cnt;
  logic             is_nop;

  assign imm_cnt  = CNT_W'(iInstruction[INSN_W-5:0]);
  assign is_nop   = (opcode == NOP_OPCODE);
  assign do_count = !iBranchTaken && !iStall &&
                    (state_q == DELAY);
`else
  // FLUSH and FETCH fetch identically here; keep them visible to lint.
  logic unused_sig;
  assign unused_sig = ^{opcode == NOP_OPCODE, state_q};
  assign do_count   = 1'b0;
`endif

  assign do_branch = iBranchTaken;
  assign do_hold   = !iBranchTaken && iStall;
  assign do_fetch  = !iBranchTaken && !iStall && !do_count;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    opc_d   = opc_q;
    insn_d  = insn_q;
    valid_d = valid_q;
`ifdef INSTRUCTION_FETCH_NOP_DELAY_EN
    cnt_d   = cnt_q;
`endif
    unique case (1'b1)
      do_branch: begin
        pc_d    = iBranchTarget;
        valid_d = 1'b0;
        state_d = FLUSH;
`ifdef INSTRUCTION_FETCH_NOP_DELAY_EN
        cnt_d   = '0;
`endif
      end
      do_hold: begin
      end
`ifdef INSTRUCTION_FETCH_NOP_DELAY_EN
      do_count: begin
        valid_d = 1'b0;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = FETCH;
      end
`endif
      do_fetch: begin
        insn_d  = iInstruction;
        opc_d   = pc_q;
        valid_d = 1'b1;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = FETCH;
`ifdef INSTRUCTION_FETCH_NOP_DELAY_EN
        // the NOP itself issues; its bubbles follow
        if (is_nop && imm_cnt != '0) begin
          state_d = DELAY;
          cnt_d   = imm_cnt;
        end
`endif
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= FETCH;
      pc_q    <= '0;
      opc_q   <= '0;
      insn_q  <= '0;
      valid_q <= 1'b0;
`ifdef INSTRUCTION_FETCH_NOP_DELAY_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      opc_q   <= opc_d;
      insn_q  <= insn_d;
      valid_q <= valid_d;
`ifdef INSTRUCTION_FETCH_NOP_DELAY_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign oAddress     = pc_q;
  assign oInstruction = insn_q;
  assign oPC          = opc_q;
  assign oValid       = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios then random stall/branch
// traffic, each cycle checked against an issue-level reference model.
module tb_instruction_fetch;
  localparam int AW = 16;
  localparam int IW = 28;
`ifdef INSTRUCTION_FETCH_NOP_DELAY_EN
  localparam bit DLY = 1'b1;
`else
  localparam bit DLY = 1'b0;
`endif

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic [AW-1:0] oAddress;
  logic [IW-1:0] iInstruction;
  logic          iStall;
  logic          iBranchTaken;
  logic [AW-1:0] iBranchTarget;
  logic [IW-1:0] oInstruction;
  logic [AW-1:0] oPC;
  logic          oValid;

  logic [IW-1:0] rom [0:65535];

  int compared   = 0;
  int mismatched = 0;

  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_opc;
  logic [IW-1:0] m_insn;
  logic          m_valid;
  int            m_delay;

  instruction_fetch dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .oAddress     (oAddress),
    .iInstruction (iInstruction),
    .iStall       (iStall),
    .iBranchTaken (iBranchTaken),
    .iBranchTarget(iBranchTarget),
    .oInstruction (oInstruction),
    .oPC          (oPC),
    .oValid       (oValid)
  );

  always #5 Clock = ~Clock;

  assign iInstruction = rom[oAddress];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = '0;
    m_opc   = '0;
    m_insn  = '0;
    m_valid = 1'b0;
    m_delay = 0;
  endtask

  // One rising edge of issue behaviour: what decode should see next.
  task automatic model_edge();
    logic [IW-1:0] w;
    if (iBranchTaken) begin
      m_pc    = iBranchTarget;
      m_valid = 1'b0;
      m_delay = 0;
    end else if (iStall) begin
    end else if (m_delay > 0) begin
      m_valid = 1'b0;
      m_delay = m_delay - 1;
    end else begin
      w       = rom[m_pc];
      m_insn  = w;
      m_opc   = m_pc;
      m_valid = 1'b1;
      m_pc    = m_pc + 1'b1;
      if (DLY && w[27:24] == 4'd0 && w[23:0] != 24'd0)
        m_delay = int'(w[23:0]);
    end
  endtask

  task automatic check_all();
    chk("addr",  32'(oAddress),     32'(m_pc));
    chk("valid", 32'(oValid),       32'(m_valid));
    chk("opc",   32'(oPC),          32'(m_opc));
    chk("insn",  32'(oInstruction), 32'(m_insn));
  endtask

  task automatic step(input bit st, input bit br,
                      input logic [AW-1:0] tg);
    iStall        = st;
    iBranchTaken  = br;
    iBranchTarget = tg;
    @(posedge Clock);
    model_edge();
    #1;
    check_all();
    iStall       = 1'b0;
    iBranchTaken = 1'b0;
  endtask

  task automatic do_reset();
    iStall       = 1'b0;
    iBranchTaken = 1'b0;
    Reset        = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge Clock);
    #1;
    check_all();
    Reset = 1'b1;
  endtask

  initial begin
    logic [AW-1:0] s_pc;
    logic [IW-1:0] s_insn;
    int            bub;
    bit            done;
    bit            stalled;
    logic [3:0]    op;
    logic [23:0]   imm;
    bit            st;
    bit            br;

    iStall        = 1'b0;
    iBranchTaken  = 1'b0;
    iBranchTarget = '0;
    for (int i = 0; i < 65536; i++)
      rom[i] = {4'h1, 24'(i)};

    #2;
    do_reset();

    // linear stream after reset release
    for (int i = 0; i < 4; i++) begin
      step(0, 0, '0);
      chk("lin_opc",   32'(oPC), i);
      chk("lin_valid", 32'(oValid), 1);
    end
    for (int i = 0; i < 4; i++) step(0, 0, '0);
    chk("pre_br_opc", 32'(oPC), 7);

    // branch while oPC=7: one bubble, ROM[8] never issued
    step(0, 1, 16'd4);
    chk("br_bubble", 32'(oValid), 0);
    chk("br_no8a", 32'(oValid && oPC == 16'd8), 0);
    step(0, 0, '0);
    chk("br_opc",  32'(oPC), 4);
    chk("br_insn", 32'(oInstruction), 32'({4'h1, 24'd4}));
    chk("br_no8b", 32'(oValid && oPC == 16'd8), 0);

    // stall mid-stream
    step(0, 0, '0);
    s_pc   = oPC;
    s_insn = oInstruction;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, '0);
      chk("stall_opc",   32'(oPC), 32'(s_pc));
      chk("stall_insn",  32'(oInstruction), 32'(s_insn));
      chk("stall_valid", 32'(oValid), 1);
    end
    step(0, 0, '0);
    chk("stall_rel_opc", 32'(oPC), 32'(s_pc) + 1);

    // NOP 4000 at address 0, with a 5-cycle stall inside the delay
    rom[0] = {4'h0, 24'd4000};
    do_reset();
    step(0, 0, '0);
    chk("nop_opc",   32'(oPC), 0);
    chk("nop_valid", 32'(oValid), 1);
    bub     = 0;
    done    = 1'b0;
    stalled = 1'b0;
    for (int k = 0; k < 5000 && !done; k++) begin
      step(0, 0, '0);
      if (oValid) done = 1'b1;
      else bub++;
      if (bub == 100 && !stalled) begin
        stalled = 1'b1;
        for (int j = 0; j < 5; j++) begin
          step(1, 0, '0);
          chk("dly_stall_valid", 32'(oValid), 0);
        end
      end
    end
    chk("nop_done",    32'(done), 1);
    chk("nop_bubbles", bub, DLY ? 4000 : 0);
    chk("nop_next",    32'(oPC), 1);

    // full-width immediate, then a branch out of the delay
    rom[0] = {4'h0, 24'hFFFFFF};
    do_reset();
    step(0, 0, '0);
    for (int i = 0; i < 30; i++) step(0, 0, '0);
    chk("big_imm_valid", 32'(oValid), DLY ? 0 : 1);
    step(0, 1, 16'h0010);
    step(0, 0, '0);
    chk("big_br_opc",   32'(oPC), 32'h10);
    chk("big_br_valid", 32'(oValid), 1);

    // PC wrap
    step(0, 1, 16'hFFFF);
    step(0, 0, '0);
    chk("wrap_ffff", 32'(oPC), 32'hFFFF);
    step(0, 0, '0);
    chk("wrap_0000",  32'(oPC), 0);
    chk("wrap_addr",  32'(oAddress), 1);

    // asynchronous reset in the middle of a delay
    rom[0] = {4'h0, 24'd50};
    do_reset();
    for (int i = 0; i < 11; i++) step(0, 0, '0);
    #2;
    Reset = 1'b0;
    model_reset();
    #1;
    chk("arst_valid", 32'(oValid), 0);
    chk("arst_opc",   32'(oPC), 0);
    chk("arst_insn",  32'(oInstruction), 0);
    chk("arst_addr",  32'(oAddress), 0);
    @(posedge Clock);
    #1;
    check_all();
    Reset = 1'b1;
    step(0, 0, '0);
    chk("arst_first", 32'(oPC), 0);

    // random traffic against the model
    for (int i = 0; i < 65536; i++) begin
      op  = 4'($urandom_range(0, 15));
      imm = (op == 4'd0) ? 24'($urandom_range(0, 6))
                         : 24'($urandom);
      rom[i] = {op, imm};
    end
    for (int i = 0; i < 3000; i++) begin
      st = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 9) == 0);
      step(st, br, 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
